// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// The parity helper is only referenced when REGFILE_PARITY_EN is defined.
package regfile_pkg;

    localparam int XLEN_D  = 32;
    localparam int NREGS_D = 32;
    localparam int X0      = 0;
    localparam int PAR_W   = 64;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic parity(input logic [PAR_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: reserve at issue, release at writeback,
// plus an incrementally maintained count of busy registers.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS = NREGS_D,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    input  logic [AW-1:0] rd,
    input  logic          regwrite,
    input  logic          rsv_en,
    input  logic [AW-1:0] rsv_rd,
    output logic          busy1,
    output logic          busy2,
    output logic [AW:0]   nbusy
);

    logic [NREGS-1:0] busy;
    logic rel;
    logic res;
    logic same;
    logic inc;
    logic dec;

    assign rel  = regwrite && (rd != AW'(X0));
    assign res  = rsv_en && (rsv_rd != AW'(X0));
    assign same = res && (rsv_rd == rd);
    assign inc  = res && !busy[rsv_rd];
    // A release cancelled by a same-edge reserve of the same register
    // leaves it busy, so it must not decrement the count.
    assign dec  = rel && busy[rd] && !same;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy  <= '0;
            nbusy <= '0;
        end else begin
            if (rel)
                busy[rd] <= 1'b0;
            if (res)
                busy[rsv_rd] <= 1'b1;
            if (inc && !dec)
                nbusy <= nbusy + (AW+1)'(1);
            else if (dec && !inc)
                nbusy <= nbusy - (AW+1)'(1);
        end
    end

    assign busy1 = (rs1 != AW'(X0)) && busy[rs1]
                   && !(rel && (rd == rs1) && !(res && (rsv_rd == rs1)));
    assign busy2 = (rs2 != AW'(X0)) && busy[rs2]
                   && !(rel && (rd == rs2) && !(res && (rsv_rd == rs2)));

endmodule

// File: rtl/regfile_sb.sv
// Register file, 2R/1W, x0 hardwired, write bypass and busy scoreboard.
// Define REGFILE_PARITY_EN to add per-register parity and perr1/perr2.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN   = XLEN_D,
    parameter  int NREGS  = NREGS_D,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] readdata1,
    output logic [XLEN-1:0] readdata2,
    output logic            busy1,
    output logic            busy2,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] writedata,
    input  logic            regwrite,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_rd,
    output logic [AW:0]     nbusy
`ifdef REGFILE_PARITY_EN
    ,
    output logic            perr1,
    output logic            perr2
`endif
);

    logic [XLEN-1:0] mem [NREGS];
    logic we;
    logic z1;
    logic z2;
    logic byp1;
    logic byp2;

    assign we   = regwrite && (rd != AW'(X0));
    assign z1   = (rs1 == AW'(X0));
    assign z2   = (rs2 == AW'(X0));
    assign byp1 = (BYPASS != 0) && regwrite && (rd == rs1);
    assign byp2 = (BYPASS != 0) && regwrite && (rd == rs2);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                mem[i] <= '0;
        end else if (we) begin
            mem[rd] <= writedata;
        end
    end

    assign readdata1 = z1 ? '0 : (byp1 ? writedata : mem[rs1]);
    assign readdata2 = z2 ? '0 : (byp2 ? writedata : mem[rs2]);

`ifdef REGFILE_PARITY_EN
    logic par [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                par[i] <= 1'b0;
        end else if (we) begin
            par[rd] <= parity(PAR_W'(writedata));
        end
    end

    assign perr1 = !z1 && !byp1
                   && (par[rs1] != parity(PAR_W'(mem[rs1])));
    assign perr2 = !z2 && !byp2
                   && (par[rs2] != parity(PAR_W'(mem[rs2])));
`endif

    regfile_scoreboard #(
        .NREGS (NREGS)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .regwrite (regwrite),
        .rsv_en   (rsv_en),
        .rsv_rd   (rsv_rd),
        .busy1    (busy1),
        .busy2    (busy2),
        .nbusy    (nbusy)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a bypassing and a non-bypassing
// instance share stimulus; a negedge monitor drains expected values.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    typedef enum int {S_RD1, S_RD2, S_B1, S_B2, S_NB, S_RD1N, S_P1, S_P2} sig_e;

    typedef struct {
        string          name;
        sig_e           sig;
        logic [31:0]    exp;
    } chk_t;

    logic            clk;
    logic            reset;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] writedata;
    logic            regwrite;
    logic            rsv_en;
    logic [AW-1:0]   rsv_rd;

    logic [XLEN-1:0] readdata1;
    logic [XLEN-1:0] readdata2;
    logic            busy1;
    logic            busy2;
    logic [AW:0]     nbusy;
    logic [XLEN-1:0] n_readdata1;
    logic [XLEN-1:0] n_readdata2;
    logic            n_busy1;
    logic            n_busy2;
    logic [AW:0]     n_nbusy;
`ifdef REGFILE_PARITY_EN
    logic            perr1;
    logic            perr2;
    logic            n_perr1;
    logic            n_perr2;
`endif

    chk_t q[$];
    int   ntests = 0;
    int   nfail  = 0;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .rs1       (rs1),
        .rs2       (rs2),
        .readdata1 (readdata1),
        .readdata2 (readdata2),
        .busy1     (busy1),
        .busy2     (busy2),
        .rd        (rd),
        .writedata (writedata),
        .regwrite  (regwrite),
        .rsv_en    (rsv_en),
        .rsv_rd    (rsv_rd),
        .nbusy     (nbusy)
`ifdef REGFILE_PARITY_EN
        ,
        .perr1     (perr1),
        .perr2     (perr2)
`endif
    );

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .rs1       (rs1),
        .rs2       (rs2),
        .readdata1 (n_readdata1),
        .readdata2 (n_readdata2),
        .busy1     (n_busy1),
        .busy2     (n_busy2),
        .rd        (rd),
        .writedata (writedata),
        .regwrite  (regwrite),
        .rsv_en    (rsv_en),
        .rsv_rd    (rsv_rd),
        .nbusy     (n_nbusy)
`ifdef REGFILE_PARITY_EN
        ,
        .perr1     (n_perr1),
        .perr2     (n_perr2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] get(input sig_e s);
        logic [31:0] v;
        v = '0;
        case (s)
            S_RD1:  v = readdata1;
            S_RD2:  v = readdata2;
            S_B1:   v = 32'(busy1);
            S_B2:   v = 32'(busy2);
            S_NB:   v = 32'(nbusy);
            S_RD1N: v = n_readdata1;
`ifdef REGFILE_PARITY_EN
            S_P1:   v = 32'(perr1);
            S_P2:   v = 32'(perr2);
`endif
            default: v = 32'hFFFF_FFFF;
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0) begin
            chk_t c;
            logic [31:0] act;
            c = q.pop_front();
            act = get(c.sig);
            ntests++;
            if (act !== c.exp) begin
                nfail++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, act, c.exp);
            end
        end
    end

    task automatic expect_v(input string n, input sig_e s, input logic [31:0] e);
        chk_t c;
        c.name = n;
        c.sig  = s;
        c.exp  = e;
        q.push_back(c);
    endtask

    task automatic drive(input logic rst, input logic we, input int wr,
                         input logic [31:0] wd, input logic re, input int rr,
                         input int a, input int b);
        @(posedge clk);
        #1;
        reset     = rst;
        regwrite  = we;
        rd        = AW'(wr);
        writedata = wd;
        rsv_en    = re;
        rsv_rd    = AW'(rr);
        rs1       = AW'(a);
        rs2       = AW'(b);
    endtask

    initial begin
        reset = 1'b1; regwrite = 1'b0; rd = '0; writedata = '0;
        rsv_en = 1'b0; rsv_rd = '0; rs1 = '0; rs2 = '0;

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        // write to x0 is dropped and x0 reads zero
        drive(0, 1, 0, 4, 0, 0, 0, 0);
        expect_v("x0_read", S_RD1, 0);
        expect_v("reset_nbusy", S_NB, 0);
        expect_v("reset_busy1", S_B1, 0);
        for (int i = 1; i <= 5; i++)
            drive(0, 1, i, 32'(i), 0, 0, 0, 0);
        drive(0, 0, 1, 4, 0, 0, 0, 1);
        expect_v("pair01_a", S_RD1, 0);
        expect_v("pair01_b", S_RD2, 1);
        drive(0, 0, 1, 4, 0, 0, 2, 3);
        expect_v("pair23_a", S_RD1, 2);
        expect_v("pair23_b", S_RD2, 3);
        drive(0, 0, 1, 4, 0, 0, 4, 5);
        expect_v("pair45_a", S_RD1, 4);
        expect_v("pair45_b", S_RD2, 5);
        expect_v("pair45_nobyp", S_RD1N, 4);
        drive(0, 0, 1, 4, 0, 0, 1, 1);
        expect_v("no_we_x1", S_RD1, 1);
        // same-cycle bypass vs stored value
        drive(0, 1, 7, 32'hDEADBEEF, 0, 0, 7, 7);
        expect_v("byp_rd1", S_RD1, 32'hDEADBEEF);
        expect_v("byp_rd2", S_RD2, 32'hDEADBEEF);
        expect_v("nobyp_before", S_RD1N, 0);
        drive(0, 0, 0, 0, 0, 0, 7, 7);
        expect_v("nobyp_after", S_RD1N, 32'hDEADBEEF);
        expect_v("byp_after", S_RD1, 32'hDEADBEEF);
        // scoreboard reserve / release
        drive(0, 0, 0, 0, 1, 3, 3, 0);
        expect_v("rsv3_pre_busy", S_B1, 0);
        drive(0, 0, 0, 0, 1, 4, 3, 0);
        expect_v("rsv3_busy", S_B1, 1);
        expect_v("rsv3_nbusy", S_NB, 1);
        drive(0, 1, 3, 32'h33, 0, 0, 3, 4);
        expect_v("rsv34_nbusy", S_NB, 2);
        expect_v("release_byp_busy", S_B1, 0);
        expect_v("x4_busy", S_B2, 1);
        expect_v("release_data", S_RD1, 32'h33);
        drive(0, 0, 0, 0, 1, 0, 3, 0);
        expect_v("after_release_nb", S_NB, 1);
        expect_v("after_release_b1", S_B1, 0);
        drive(0, 0, 0, 0, 1, 6, 0, 0);
        expect_v("rsv_x0_nbusy", S_NB, 1);
        expect_v("x0_busy", S_B1, 0);
        // same-edge release and reserve of x6
        drive(0, 1, 6, 32'h66, 1, 6, 6, 0);
        expect_v("x6_rsv_nb", S_NB, 2);
        expect_v("x6_same_busy", S_B1, 1);
        expect_v("x6_same_data", S_RD1, 32'h66);
        // release x4, reserve x8 on the same edge
        drive(0, 1, 4, 32'h44, 1, 8, 6, 8);
        expect_v("x6_after_nb", S_NB, 2);
        expect_v("x6_after_busy", S_B1, 1);
        expect_v("x6_after_data", S_RD1, 32'h66);
        expect_v("x8_pre_busy", S_B2, 0);
        drive(0, 0, 0, 0, 0, 0, 4, 8);
        expect_v("swap_nb", S_NB, 2);
        expect_v("x4_released", S_B1, 0);
        expect_v("x8_busy", S_B2, 1);
        expect_v("x4_data", S_RD1, 32'h44);
`ifdef REGFILE_PARITY_EN
        expect_v("perr1_clean", S_P1, 0);
        expect_v("perr2_clean", S_P2, 0);
`endif
        // reset wins over concurrent write and reserve
        drive(1, 1, 2, 9, 1, 5, 2, 5);
        expect_v("pre_reset_nb", S_NB, 2);
        drive(0, 0, 0, 0, 0, 0, 2, 5);
        expect_v("reset_x2", S_RD1, 0);
        expect_v("reset_x2_nobyp", S_RD1N, 0);
        expect_v("reset_busy5", S_B2, 0);
        expect_v("reset_nbusy2", S_NB, 0);
        drive(0, 0, 0, 0, 0, 0, 7, 8);
        expect_v("reset_x7", S_RD1, 0);
        expect_v("reset_busy8", S_B2, 0);
`ifdef REGFILE_PARITY_EN
        expect_v("reset_perr1", S_P1, 0);
        drive(0, 1, 3, 32'h7, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 3, 3);
        expect_v("par_ok", S_P1, 0);
        @(negedge clk);
        #1;
        dut.par[3] = ~dut.par[3];
        expect_v("par_flip", S_P1, 1);
`endif

        for (int k = 0; k < 10 && q.size() > 0; k++)
            @(posedge clk);
        if (q.size() > 0) begin
            ntests++;
            nfail++;
            $display("FAIL drain: %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
